// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT bin sequencer: FSM state encoding
// and the default twiddle/bin address width.
package sdft_pkg;

    localparam int SDFT_ADDR_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/sdft_sequencer.sv
// Sliding-DFT bin sequencer: on each accepted sample, walks the twiddle ROM
// address 0..LAST_BIN (stallable by hold) and flags bins aligned with ROM data.
module sdft_sequencer
    import sdft_pkg::*;
#(
    parameter int ADDR_W   = SDFT_ADDR_W,
    parameter int LAST_BIN = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic              hold,
    input  logic              clear_overrun,
    output logic              ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              bin_valid,
    output logic [ADDR_W-1:0] bin_idx,
    output logic              bin_first,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_BIN);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [ADDR_W-1:0] addr_d;
    logic              issue_p0;
    logic              overrun_evt;

    assign ready       = (state_q == IDLE);
    assign overrun_evt = sample_valid & ~ready;

    // Stage p0: address issue; the ROM registers rom_addr during this cycle
    always_comb begin
        state_d  = state_q;
        addr_d   = rom_addr;
        issue_p0 = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (sample_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    issue_p0 = 1'b1;
                    if (rom_addr == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = IDLE;
                    end else begin
                        addr_d = rom_addr + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rom_addr <= '0;
        end else begin
            state_q  <= state_d;
            rom_addr <= addr_d;
        end
    end

    // Stage p1: bin qualifiers line up with the ROM's registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_valid  <= 1'b0;
            bin_idx    <= '0;
            bin_first  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bin_valid  <= issue_p0;
            bin_first  <= issue_p0 && (rom_addr == '0);
            frame_done <= issue_p0 && (rom_addr == LAST_ADDR);
            if (issue_p0) begin
                bin_idx <= rom_addr;
            end
        end
    end

    // A fresh overrun event wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (overrun_evt) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdft_sequencer.sv
// Directed bench for sdft_sequencer (ADDR_W=3, LAST_BIN=7) with per-cycle
// hand-derived expectations for four scenarios.
module tb_sdft_sequencer;

    localparam int ADDR_W   = 3;
    localparam int LAST_BIN = 7;
    localparam int NCYC     = 36;

    logic              clk;
    logic              reset_n;
    logic              sample_valid;
    logic              hold;
    logic              clear_overrun;
    logic              ready;
    logic [ADDR_W-1:0] rom_addr;
    logic              bin_valid;
    logic [ADDR_W-1:0] bin_idx;
    logic              bin_first;
    logic              frame_done;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int valid;
        int idx;
        int first;
        int done;
        int rdy;
        int addr;
        int ovr;
    } exp_t;

    sdft_sequencer #(
        .ADDR_W   (ADDR_W),
        .LAST_BIN (LAST_BIN)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_valid  (sample_valid),
        .hold          (hold),
        .clear_overrun (clear_overrun),
        .ready         (ready),
        .rom_addr      (rom_addr),
        .bin_valid     (bin_valid),
        .bin_idx       (bin_idx),
        .bin_first     (bin_first),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scenario 1: plain frame, hold in IDLE, dropped sample -> overrun, clear
    // Scenario 2: hold at cycles 14-15 mid-frame
    // Scenario 3: back-to-back frames, overrun with simultaneous clear
    // Scenario 4: async reset at cycle 15 mid-frame, restart at 18
    function automatic exp_t expect_at(int scn, int c);
        exp_t e;
        e = '{valid: 0, idx: 0, first: 0, done: 0, rdy: 1, addr: 0, ovr: 0};
        case (scn)
            1: begin
                if (c >= 11 && c <= 18) begin e.rdy = 0; e.addr = c - 11; end
                if (c >= 12 && c <= 19) begin e.valid = 1; e.idx = c - 12; end
                else if (c > 19) e.idx = 7;
                e.first = int'(c == 12);
                e.done  = int'(c == 19);
                e.ovr   = int'(c >= 14 && c <= 25);
            end
            2: begin
                if (c >= 11 && c <= 20) e.rdy = 0;
                if (c >= 11 && c <= 14) e.addr = c - 11;
                else if (c == 15 || c == 16) e.addr = 3;
                else if (c >= 17 && c <= 20) e.addr = c - 13;
                if (c >= 12 && c <= 14) begin e.valid = 1; e.idx = c - 12; end
                else if (c == 15 || c == 16) e.idx = 2;
                else if (c >= 17 && c <= 21) begin e.valid = 1; e.idx = c - 14; end
                else if (c > 21) e.idx = 7;
                e.first = int'(c == 12);
                e.done  = int'(c == 21);
            end
            3: begin
                if ((c >= 11 && c <= 18) || (c >= 20 && c <= 27)) e.rdy = 0;
                if (c >= 11 && c <= 18) e.addr = c - 11;
                else if (c >= 20 && c <= 27) e.addr = c - 20;
                if (c >= 12 && c <= 19) begin e.valid = 1; e.idx = c - 12; end
                else if (c == 20) e.idx = 7;
                else if (c >= 21 && c <= 28) begin e.valid = 1; e.idx = c - 21; end
                else if (c > 28) e.idx = 7;
                e.first = int'(c == 12 || c == 21);
                e.done  = int'(c == 19 || c == 28);
                e.ovr   = int'(c >= 23 && c <= 30);
            end
            default: begin
                if ((c >= 11 && c <= 14) || (c >= 19 && c <= 26)) e.rdy = 0;
                if (c >= 11 && c <= 14) e.addr = c - 11;
                else if (c >= 19 && c <= 26) e.addr = c - 19;
                if (c >= 12 && c <= 14) begin e.valid = 1; e.idx = c - 12; end
                else if (c >= 20 && c <= 27) begin e.valid = 1; e.idx = c - 20; end
                else if (c > 27) e.idx = 7;
                e.first = int'(c == 12 || c == 20);
                e.done  = int'(c == 27);
            end
        endcase
        return e;
    endfunction

    task automatic drive_inputs(input int scn, input int c);
        sample_valid  = 1'b0;
        hold          = 1'b0;
        clear_overrun = 1'b0;
        case (scn)
            1: begin
                sample_valid  = (c == 10 || c == 13);
                hold          = (c >= 5 && c <= 10);
                clear_overrun = (c == 25);
            end
            2: begin
                sample_valid = (c == 10);
                hold         = (c == 14 || c == 15);
            end
            3: begin
                sample_valid  = (c == 10 || c == 19 || c == 22);
                clear_overrun = (c == 22 || c == 30);
            end
            default: begin
                sample_valid = (c == 10 || c == 18);
                if (c == 15) reset_n = 1'b0;
                if (c == 16) reset_n = 1'b1;
            end
        endcase
    endtask

    task automatic check_outputs(input int scn, input int c);
        exp_t e;
        string p;
        e = expect_at(scn, c);
        p = $sformatf("s%0d c%0d", scn, c);
        chk({p, " bin_valid"},  int'(bin_valid),  e.valid);
        chk({p, " bin_idx"},    int'(bin_idx),    e.idx);
        chk({p, " bin_first"},  int'(bin_first),  e.first);
        chk({p, " frame_done"}, int'(frame_done), e.done);
        chk({p, " ready"},      int'(ready),      e.rdy);
        chk({p, " rom_addr"},   int'(rom_addr),   e.addr);
        chk({p, " overrun"},    int'(overrun),    e.ovr);
    endtask

    task automatic run_scn(input int scn);
        reset_n       = 1'b0;
        sample_valid  = 1'b0;
        hold          = 1'b0;
        clear_overrun = 1'b0;
        @(negedge clk);
        chk($sformatf("s%0d rst ready", scn),     int'(ready),      1);
        chk($sformatf("s%0d rst rom_addr", scn),  int'(rom_addr),   0);
        chk($sformatf("s%0d rst bin_valid", scn), int'(bin_valid),  0);
        chk($sformatf("s%0d rst bin_idx", scn),   int'(bin_idx),    0);
        chk($sformatf("s%0d rst overrun", scn),   int'(overrun),    0);
        chk($sformatf("s%0d rst frame_done", scn), int'(frame_done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            drive_inputs(scn, c);
            @(negedge clk);
            check_outputs(scn, c);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        sample_valid  = 1'b0;
        hold          = 1'b0;
        clear_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 1; s <= 4; s++) begin
            run_scn(s);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdft_sequencer.md
SDFT_SEQUENCER -- requirements
Module: sdft_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the bin/twiddle address width.
REQ-002 SHALL have parameter LAST_BIN, default (1<<ADDR_W)-1, meaning the highest bin index processed per sample.
REQ-003 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sample_valid, input, 1, one-cycle pulse: new sample delta available to the datapath.
REQ-006 SHALL have port hold, input, 1, datapath back-pressure: freeze bin issue while high.
REQ-007 SHALL have port clear_overrun, input, 1, clears the sticky overrun flag.
REQ-008 SHALL have port ready, output, 1, high when a sample can be accepted.
REQ-009 SHALL have port rom_addr, output, ADDR_W, registered twiddle ROM address (ROM has 1-cycle registered read).
REQ-010 SHALL have port bin_valid, output, 1, twiddle ROM data and bin_idx are valid this cycle.
REQ-011 SHALL have port bin_idx, output, ADDR_W, bin index aligned with bin_valid and ROM data.
REQ-012 SHALL have port bin_first, output, 1, qualifies bin_valid for bin 0.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse coincident with the bin_valid of LAST_BIN.
REQ-014 SHALL have port overrun, output, 1, sticky: sample_valid arrived while not ready.

Function
REQ-015 SHALL implement states IDLE and RUN; ready = (state==IDLE).
REQ-016 IDLE: sample_valid SHALL move to RUN next cycle with rom_addr=0; else remain IDLE with rom_addr=0.
REQ-017 RUN, hold low: the cycle's rom_addr SHALL be "issued"; rom_addr increments by 1, or on issuing LAST_BIN, returns to 0 and the state goes to IDLE.
REQ-018 RUN, hold high: rom_addr and state SHALL hold; nothing issued.
REQ-019 An address issued in cycle t SHALL produce bin_valid=1, bin_idx=that address, in cycle t+1; otherwise bin_valid=0 and bin_idx holds its last value.
REQ-020 Latency: sample_valid at cycle t, no hold -> first bin_valid at t+2, frame_done at t+2+LAST_BIN, ready again at t+2+LAST_BIN; minimum sample period LAST_BIN+2 cycles.
REQ-021 sample_valid while ready=0 SHALL be dropped (sequence unaffected) and set overrun.
REQ-022 clear_overrun SHALL clear overrun next cycle; simultaneous clear_overrun and new overrun event SHALL leave overrun set.
REQ-023 hold while in IDLE SHALL have no effect; sample acceptance is not gated by hold.
REQ-024 rom_addr SHALL never exceed LAST_BIN; counter arithmetic ADDR_W bits, no wrap past LAST_BIN.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, rom_addr=0, bin_idx=0, bin_valid=0, bin_first=0, frame_done=0, overrun=0; ready=1.
REQ-026 Reset mid-RUN SHALL abort the frame without a frame_done pulse; the first sample after release starts at bin 0.

Structure
REQ-027 State enum and default ADDR_W SHALL live in shared package sdft_pkg.
REQ-028 No sub-module; twiddle_rom SHALL be instantiated by the parent and fed rom_addr.

Verification (bench ADDR_W=3, LAST_BIN=7)
REQ-029 sample_valid at cycle 10, hold=0 -> bin_valid cycles 12..19, bin_idx 0..7, bin_first at 12, frame_done at 19, ready high from 19.
REQ-030 hold high at cycles 14-15 during the above frame -> bin_valid low at 15-16, bin_idx 3 at 17, frame_done at 21.
REQ-031 second sample_valid at cycle 13 -> ignored, overrun=1 from 14; clear_overrun at 25 -> overrun=0 at 26.
REQ-032 reset_n low at cycle 15 mid-frame -> immediately bin_valid=0, rom_addr=0, ready=1; no frame_done; next sample yields bins 0..7.
REQ-033 back-to-back: sample_valid at 10 and 19 -> bin_valid continuous except cycle 20; second frame_done at 28.
